// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// Module  : shift_pkg
// Brief   : Mode encodings and direction constants for shiftreg_prog.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_ROT  = 2'b01,
    MODE_SHIN = 2'b10,
    MODE_SHZ  = 2'b11
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/prescaler_tick.sv
// ---------------------------------------------------------------------------
// Module  : prescaler_tick
// Brief   : Free-running N-bit counter; tick is high while the count is all-ones.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prescaler_tick #(
  parameter int N = 21
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  assign cnt_d = cnt_q + N'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = &cnt_q;

endmodule

`default_nettype wire

// File: rtl/shiftreg_prog.sv
// ---------------------------------------------------------------------------
// Module  : shiftreg_prog
// Brief   : Programmable rotate/shift register stepped by a prescaled tick.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shiftreg_prog
  import shift_pkg::*;
#(
  parameter int          WIDTH = 4,
  parameter int          NP    = 21,
  parameter logic [31:0] INI   = 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             serin,
  input  logic             en,
  output logic [WIDTH-1:0] data,
  output logic             serout,
  output logic             tick,
  output logic             wrap
);

  localparam int             CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

  logic             tick_w;
  logic             step_w;
  logic             in_bit_w;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic             wrap_q, wrap_d;

  prescaler_tick #(.N(NP)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_w)
  );

  // Load wins over a coincident step.
  assign step_w   = tick_w && en && !load && (mode != MODE_HOLD);
  assign in_bit_w = (mode == MODE_SHIN) ? serin : 1'b0;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      data_d = ld_data;
      cnt_d  = '0;
    end else if (step_w) begin
      if (mode == MODE_ROT) begin
        data_d = (dir == DIR_RIGHT) ? {data_q[0], data_q[WIDTH-1:1]}
                                    : {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      end else begin
        data_d = (dir == DIR_RIGHT) ? {in_bit_w, data_q[WIDTH-1:1]}
                                    : {data_q[WIDTH-2:0], in_bit_w};
      end
      if (cnt_q == LAST_STEP) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= INI[WIDTH-1:0];
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign data   = data_q;
  assign serout = (dir == DIR_RIGHT) ? data_q[0] : data_q[WIDTH-1];
  assign tick   = tick_w;
  assign wrap   = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_shiftreg_prog.sv
// ---------------------------------------------------------------------------
// Module  : tb_shiftreg_prog
// Brief   : Scoreboard bench for shiftreg_prog (WIDTH=4, NP=2, INI=1).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shiftreg_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] ld_data;
  logic [1:0] mode;
  logic       dir;
  logic       serin;
  logic       en;
  logic [3:0] data;
  logic       serout;
  logic       tick;
  logic       wrap;

  shiftreg_prog #(.WIDTH(4), .NP(2), .INI(32'd1)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .ld_data (ld_data),
    .mode    (mode),
    .dir     (dir),
    .serin   (serin),
    .en      (en),
    .data    (data),
    .serout  (serout),
    .tick    (tick),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       wrap;
    logic       tick;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [3:0] m_data = 4'b0001;
  logic [1:0] m_pre  = 2'd0;
  int         m_cnt  = 0;
  logic       m_wrap = 1'b0;
  logic       last_was_tick = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic cyc();
    exp_t e;
    logic tk;
    logic b;
    tk = (m_pre == 2'd3);
    if (rst) begin
      m_data = 4'b0001; m_pre = 2'd0; m_cnt = 0; m_wrap = 1'b0;
    end else begin
      m_pre  = m_pre + 2'd1;
      m_wrap = 1'b0;
      if (load) begin
        m_data = ld_data;
        m_cnt  = 0;
      end else if (tk && en && mode != 2'b00) begin
        if (mode == 2'b01) begin
          m_data = dir ? {m_data[0], m_data[3:1]} : {m_data[2:0], m_data[3]};
        end else begin
          b = (mode == 2'b10) ? serin : 1'b0;
          m_data = dir ? {b, m_data[3:1]} : {m_data[2:0], b};
        end
        m_cnt = m_cnt + 1;
        if (m_cnt == 4) begin
          m_cnt  = 0;
          m_wrap = 1'b1;
        end
      end
    end
    last_was_tick = tk && !rst;
    e.data = m_data;
    e.wrap = m_wrap;
    e.tick = (m_pre == 2'd3);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_data",   32'(data),   32'(e.data));
    check("sb_wrap",   32'(wrap),   32'(e.wrap));
    check("sb_tick",   32'(tick),   32'(e.tick));
    check("sb_serout", 32'(serout), 32'(dir ? e.data[0] : e.data[3]));
  endtask

  // Clock until an edge on which tick was high; n = cycles taken.
  task automatic to_tick_edge(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!last_was_tick && n < 16);
    check("tick_seen", 32'(last_was_tick), 32'd1);
  endtask

  task automatic step_expect(input string tag, input logic [3:0] d, input logic w);
    int n;
    to_tick_edge(n);
    check({tag, "_data"}, 32'(data), 32'(d));
    check({tag, "_wrap"}, 32'(wrap), 32'(w));
  endtask

  initial begin
    int n;
    rst = 1'b1; load = 1'b0; ld_data = 4'b0000; mode = 2'b00;
    dir = 1'b0; serin = 1'b0; en = 1'b0;
    cyc(); cyc();
    check("rst_data", 32'(data), 32'h1);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    rst = 1'b0;

    // Rotate left from reset value
    mode = 2'b01; dir = 1'b0; en = 1'b1;
    step_expect("rotl1", 4'b0010, 1'b0);
    step_expect("rotl2", 4'b0100, 1'b0);
    step_expect("rotl3", 4'b1000, 1'b0);
    step_expect("rotl4", 4'b0001, 1'b1);
    cyc();
    check("wrap_one_cycle", 32'(wrap), 32'h0);

    // Hold mode on a tick leaves data alone
    mode = 2'b00;
    step_expect("hold", 4'b0001, 1'b0);

    // Load then rotate right
    load = 1'b1; ld_data = 4'b1011; mode = 2'b01; dir = 1'b1;
    cyc();
    load = 1'b0;
    check("load_data", 32'(data), 32'hB);
    check("serout_pre", 32'(serout), 32'h1);
    step_expect("rotr1", 4'b1101, 1'b0);
    step_expect("rotr2", 4'b1110, 1'b0);
    step_expect("rotr3", 4'b0111, 1'b0);
    step_expect("rotr4", 4'b1011, 1'b1);

    // Shift in ones, then zero fill
    load = 1'b1; ld_data = 4'b0000; mode = 2'b10; dir = 1'b0; serin = 1'b1;
    cyc();
    load = 1'b0;
    step_expect("shin1", 4'b0001, 1'b0);
    step_expect("shin2", 4'b0011, 1'b0);
    step_expect("shin3", 4'b0111, 1'b0);
    step_expect("shin4", 4'b1111, 1'b1);
    mode = 2'b11;
    step_expect("shz1", 4'b1110, 1'b0);
    step_expect("shz2", 4'b1100, 1'b0);

    // Load coinciding with tick: no step, counter cleared, phase kept
    mode = 2'b01; dir = 1'b0;
    while (m_pre != 2'd3) cyc();
    check("tick_before_load", 32'(tick), 32'h1);
    load = 1'b1; ld_data = 4'b0110;
    cyc();
    load = 1'b0;
    check("load_tick_data", 32'(data), 32'h6);
    to_tick_edge(n);
    check("load_tick_phase", 32'(n), 32'd4);
    check("load_tick_step1", 32'(data), 32'hC);
    step_expect("lt2", 4'b1001, 1'b0);
    step_expect("lt3", 4'b0011, 1'b0);
    step_expect("lt4", 4'b0110, 1'b1);

    // Enable low across two ticks freezes data and counter
    load = 1'b1; ld_data = 4'b0001;
    cyc();
    load = 1'b0;
    step_expect("en1", 4'b0010, 1'b0);
    step_expect("en2", 4'b0100, 1'b0);
    en = 1'b0;
    repeat (8) cyc();
    check("en_frozen", 32'(data), 32'h4);
    en = 1'b1;
    step_expect("en3", 4'b1000, 1'b0);
    step_expect("en4", 4'b0001, 1'b1);

    // Reset on the tick edge that would have wrapped
    load = 1'b1; ld_data = 4'b0001;
    cyc();
    load = 1'b0;
    step_expect("pr1", 4'b0010, 1'b0);
    step_expect("pr2", 4'b0100, 1'b0);
    step_expect("pr3", 4'b1000, 1'b0);
    while (m_pre != 2'd3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_data", 32'(data), 32'h1);
    check("midrst_wrap", 32'(wrap), 32'h0);
    check("midrst_tick", 32'(tick), 32'h0);
    to_tick_edge(n);
    check("midrst_phase", 32'(n), 32'd4);
    check("midrst_step", 32'(data), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/shiftreg_prog.md
SHIFTREG_PROG -- requirements
Module: shiftreg_prog

Interface
REQ-001 Parameter WIDTH, default 4: register width in bits; legal range 2..32.
REQ-002 Parameter NP, default 21: prescaler bits; one shift step every 2^NP clk cycles; legal range 1..24.
REQ-003 Parameter INI, default 1: value loaded into data at reset, truncated to WIDTH bits.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 load  input  1  parallel load request, sampled every clk edge.
REQ-007 ld_data  input  WIDTH  parallel load value.
REQ-008 mode  input  2  00 hold, 01 rotate, 10 shift with serin, 11 shift with zero fill.
REQ-009 dir  input  1  0 shifts toward MSB (left), 1 shifts toward LSB (right).
REQ-010 serin  input  1  serial input bit for mode 10.
REQ-011 en  input  1  step enable; 0 freezes data and the step counter.
REQ-012 data  output  WIDTH  register contents, registered.
REQ-013 serout  output  1  bit that leaves on the next step: data[WIDTH-1] when dir=0, data[0] when dir=1; combinational from data.
REQ-014 tick  output  1  one-clk-wide pulse marking a step opportunity.
REQ-015 wrap  output  1  one-clk-wide registered pulse after WIDTH completed steps since the last load or reset.

Function
REQ-016 The prescaler is a free-running NP-bit counter in the clk domain, incrementing every cycle and wrapping from all-ones to 0; no derived clock is used.
REQ-017 tick is high exactly in cycles where the prescaler count equals all-ones; period 2^NP clk cycles.
REQ-018 A step occurs on a clk edge where tick=1, en=1, load=0 and mode!=00.
REQ-019 Rotate step: dir=0 gives data <= {data[WIDTH-2:0], data[WIDTH-1]}; dir=1 gives data <= {data[0], data[WIDTH-1:1]}.
REQ-020 Shift step: the incoming bit is serin in mode 10 and 0 in mode 11; it enters at LSB when dir=0 and at MSB when dir=1.
REQ-021 load=1 sets data <= ld_data on that edge regardless of tick, en or mode, and clears the step counter; load has priority over a coincident step.
REQ-022 load does not disturb the prescaler; tick phase is continuous across loads.
REQ-023 The step counter (width clog2(WIDTH)+1) increments on each step; when it reaches WIDTH-1 and a step occurs, it returns to 0 and wrap pulses high on the following cycle.
REQ-024 Mode 00, en=0, or tick=0 hold data and the step counter unchanged.
REQ-025 mode, dir and serin are sampled only on the step edge; changes between ticks have no effect until then.
REQ-026 Latency: data reflects a step or a load one clk edge after the qualifying edge inputs; serout follows data combinationally.

Reset
REQ-027 rst=1 at a clk edge sets data=INI[WIDTH-1:0], prescaler=0, step counter=0, wrap=0; tick is therefore 0 during the cycle after reset.
REQ-028 rst has priority over load and step; asserting rst mid-operation discards any step pending in that cycle.

Structure
REQ-029 Mode encodings (MODE_HOLD, MODE_ROT, MODE_SHIN, MODE_SHZ) and the direction constants live in shared package shift_pkg.
REQ-030 The tick generator is a sub-module prescaler_tick (parameter N, ports clk, rst, tick); the register, step counter and wrap logic stay in shiftreg_prog.

Verification (WIDTH=4, NP=2, INI=1; tick every 4 cycles)
REQ-031 Reset, then mode=01, dir=0, en=1 for 16 cycles -> data 0001, 0010, 0100, 1000, 0001 at successive ticks; wrap pulses once, after the 4th step.
REQ-032 load ld_data=1011, then mode=01, dir=1 -> data 1101, 1110, 0111, 1011 at successive ticks; serout before step 1 = 1.
REQ-033 mode=10, dir=0, serin=1 from data=0000 -> 0001, 0011, 0111, 1111; then mode=11 -> 1110, 1100.
REQ-034 load asserted in the same cycle as tick with ld_data=0110 -> data=0110, no step applied, step counter 0, next tick phase unchanged.
REQ-035 en=0 across two ticks during rotate -> data and step counter frozen; wrap is delayed by exactly two tick periods.
REQ-036 rst asserted mid-rotate on a tick edge -> data=0001, wrap=0, first tick 4 cycles after rst is released.
